cnn_frame_streamer: RTL

- Hardware image source for the MNIST CNN pipeline. It replaces bench-side pixel driving into conv1_layer.
- A host writes one 28x28 frame, one byte at a time, over a valid/ready interface into an internal 784x8 buffer.
- The block then resets the CNN pipeline and streams the frame at one pixel per clock with no gaps.
- It captures the comparator decision and returns it to the host over a second valid/ready interface.

---
 rtl/cnn_stream_pkg.sv | 24 ++
 rtl/cnn_frame_buffer.sv | 37 +++
 rtl/cnn_frame_streamer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_stream_pkg
// Brief    : Shared FSM encoding, frame geometry defaults and timeout code
// Revision : 1.0
// ============================================================================
package cnn_stream_pkg;

    localparam int c_NUM_PIXELS = 784;
    localparam int c_PIX_BITS   = 8;
    localparam int c_IDX_BITS   = 10;

    localparam logic [3:0] c_TIMEOUT_DEC = 4'hF;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        CNN_RST = 3'd1,
        STREAM  = 3'd2,
        WAIT    = 3'd3,
        REPORT  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cnn_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_frame_buffer
// Brief    : Single-port frame RAM, synchronous write and one-cycle read
// Revision : 1.0
// ============================================================================
module cnn_frame_buffer
    import cnn_stream_pkg::*;
#(
    parameter int DEPTH = c_NUM_PIXELS,
    parameter int WIDTH = c_PIX_BITS,
    parameter int AW    = c_IDX_BITS
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cnn_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_frame_streamer
// Brief    : Loads a frame from the host, streams it into the CNN, returns the
//            decision. Optional result watchdog enabled by CNN_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module cnn_frame_streamer
    import cnn_stream_pkg::*;
#(
    parameter int NUM_PIXELS     = c_NUM_PIXELS,
    parameter int PIX_BITS       = c_PIX_BITS,
    parameter int IDX_BITS       = c_IDX_BITS,
    parameter int CNN_RST_CYCLES = 2
`ifdef CNN_TIMEOUT_EN
    ,
    parameter int TIMEOUT        = 4096
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PIX_BITS-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PIX_BITS-1:0] pix_out,
    output logic                pix_valid,
    output logic                cnn_rst_n,
    input  logic [3:0]          dec_in,
    input  logic                dec_valid,
    output logic [3:0]          res_decision,
    output logic                res_error,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy
);

    localparam logic [IDX_BITS-1:0] c_LAST_PIX = IDX_BITS'(NUM_PIXELS - 1);
    localparam logic [IDX_BITS-1:0] c_LAST_RST = IDX_BITS'(CNN_RST_CYCLES - 1);
    localparam logic [IDX_BITS-1:0] c_ONE      = IDX_BITS'(1);

    state_e              r_state, w_state_nxt;
    // One index serves as write pointer, reset-pulse counter and read pointer.
    logic [IDX_BITS-1:0] r_idx, w_idx_nxt;
    logic [IDX_BITS-1:0] w_addr;
    logic                r_dec_got, w_dec_got_nxt;
    logic [3:0]          r_dec, w_dec_nxt;
    logic                w_we, w_re;
    logic [PIX_BITS-1:0] w_rdata;

`ifdef CNN_TIMEOUT_EN
    localparam int                  c_TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TCNT_W-1:0] c_LAST_T = c_TCNT_W'(TIMEOUT - 1);
    localparam logic [c_TCNT_W-1:0] c_T_ONE  = c_TCNT_W'(1);

    logic [c_TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
    logic                r_err, w_err_nxt;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_dec_got_nxt = r_dec_got;
        w_dec_nxt     = r_dec;
        w_we          = 1'b0;
        w_re          = 1'b0;
        w_addr        = r_idx;
`ifdef CNN_TIMEOUT_EN
        w_tcnt_nxt    = r_tcnt;
        w_err_nxt     = r_err;
`endif
        case (r_state)
            LOAD: begin
                if (in_valid) begin
                    w_we = 1'b1;
                    if (r_idx == c_LAST_PIX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = CNN_RST;
                    end else begin
                        w_idx_nxt = r_idx + c_ONE;
                    end
                end
            end
            CNN_RST: begin
                if (r_idx == c_LAST_RST) begin
                    // Prefetch pixel 0 so it is on pix_out in the first STREAM cycle.
                    w_re        = 1'b1;
                    w_addr      = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = STREAM;
                end else begin
                    w_idx_nxt = r_idx + c_ONE;
                end
            end
            STREAM: begin
                w_addr = r_idx + c_ONE;
                if (dec_valid && !r_dec_got) begin
                    w_dec_got_nxt = 1'b1;
                    w_dec_nxt     = dec_in;
                end
                if (r_idx == c_LAST_PIX) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = (r_dec_got || dec_valid) ? REPORT : WAIT;
`ifdef CNN_TIMEOUT_EN
                    w_tcnt_nxt  = '0;
`endif
                end else begin
                    w_re      = 1'b1;
                    w_idx_nxt = r_idx + c_ONE;
                end
            end
            WAIT: begin
                if (dec_valid) begin
                    w_dec_got_nxt = 1'b1;
                    w_dec_nxt     = dec_in;
                    w_state_nxt   = REPORT;
                end
`ifdef CNN_TIMEOUT_EN
                else if (r_tcnt == c_LAST_T) begin
                    w_dec_nxt   = c_TIMEOUT_DEC;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = REPORT;
                end else begin
                    w_tcnt_nxt = r_tcnt + c_T_ONE;
                end
`endif
            end
            REPORT: begin
                if (res_ready) begin
                    w_dec_got_nxt = 1'b0;
                    w_state_nxt   = LOAD;
`ifdef CNN_TIMEOUT_EN
                    w_err_nxt     = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = LOAD;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= LOAD;
            r_idx     <= '0;
            r_dec_got <= 1'b0;
            r_dec     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_dec_got <= w_dec_got_nxt;
            r_dec     <= w_dec_nxt;
        end
    end

`ifdef CNN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign res_error = r_err;
`else
    assign res_error = 1'b0;
`endif

    cnn_frame_buffer #(
        .DEPTH (NUM_PIXELS),
        .WIDTH (PIX_BITS),
        .AW    (IDX_BITS)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_addr),
        .i_wdata (in_data),
        .o_rdata (w_rdata)
    );

    assign in_ready     = (r_state == LOAD);
    assign busy         = (r_state != LOAD);
    assign cnn_rst_n    = (r_state != CNN_RST);
    assign pix_valid    = (r_state == STREAM);
    // RAM output keeps stale data outside STREAM, so it is gated here.
    assign pix_out      = pix_valid ? w_rdata : '0;
    assign res_valid    = (r_state == REPORT);
    assign res_decision = r_dec;

endmodule
`default_nettype wire
